// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a byte RAM with combinational read data.
// One access in flight: grant cycle, RAM cycle, response cycle.
module mem_arbiter #(
    parameter int FAIR = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_u_b_h_w,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_u_b_h_w,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    output logic        ram_we,
    output logic [2:0]  ram_u_b_h_w,
    input  logic [31:0] ram_dout
);

    // state  | meaning
    // IDLE   | waiting for a request; winner's gnt pulses in this cycle
    // ACCESS | RAM driven from latched request; write strobe, read data captured
    // RESP   | owner's rvalid pulse with rdata/err

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic        owner_q;
    logic        last_m1_q;
    logic        mis_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  size_q;

    logic        any_req;
    logic        accept;
    logic        win_m1;
    logic        sel_we;
    logic        sel_mis;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  sel_size;

    assign any_req = m0_req | m1_req;

    always_comb begin
        win_m1 = 1'b0;
        if (m1_req && !m0_req) begin
            win_m1 = 1'b1;
        end else if (m1_req && m0_req && (FAIR != 0)) begin
            win_m1 = !last_m1_q;
        end
    end

    assign sel_we    = win_m1 ? m1_we      : m0_we;
    assign sel_addr  = win_m1 ? m1_addr    : m0_addr;
    assign sel_wdata = win_m1 ? m1_wdata   : m0_wdata;
    assign sel_size  = win_m1 ? m1_u_b_h_w : m0_u_b_h_w;

    // word size takes precedence if both size bits are set
    assign sel_mis = sel_size[1] ? (sel_addr[1:0] != 2'b00)
                                 : (sel_size[0] & sel_addr[0]);

    // grant is decided in the IDLE cycle itself so the RAM cycle follows directly
    assign accept = rst_n && (state == IDLE) && any_req;
    assign m0_gnt = accept && !win_m1;
    assign m1_gnt = accept && win_m1;

    assign ram_addr    = addr_q;
    assign ram_din     = wdata_q;
    assign ram_u_b_h_w = size_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_q   <= 1'b0;
            last_m1_q <= 1'b1;
            mis_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            ram_we    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            ram_we    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_q   <= win_m1;
                        last_m1_q <= win_m1;
                        mis_q     <= sel_mis;
                        addr_q    <= sel_addr;
                        wdata_q   <= sel_wdata;
                        size_q    <= sel_size;
                        ram_we    <= sel_we & ~sel_mis;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata     <= mis_q ? 32'h0 : ram_dout;
                    err       <= mis_q;
                    m0_rvalid <= ~owner_q;
                    m1_rvalid <= owner_q;
                    state     <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-RAM model, directed vector table, fairness and
// reset sequences, then random traffic against a byte-array reference model.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [2:0]  m0_u_b_h_w, m1_u_b_h_w;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, err, ram_we;
    logic [31:0] rdata, ram_addr, ram_din, ram_dout;
    logic [2:0]  ram_u_b_h_w;

    logic        f_m0_gnt, f_m1_gnt, f_m0_rvalid, f_m1_rvalid, f_err, f_ram_we;
    logic [31:0] f_rdata, f_ram_addr, f_ram_din, f_ram_dout;
    logic [2:0]  f_ram_u_b_h_w;
    assign f_ram_dout = 32'h0;

    mem_arbiter #(.FAIR(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_u_b_h_w(m0_u_b_h_w),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_u_b_h_w(m1_u_b_h_w),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .rdata(rdata), .err(err), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_u_b_h_w(ram_u_b_h_w), .ram_dout(ram_dout)
    );

    mem_arbiter #(.FAIR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_u_b_h_w(m0_u_b_h_w),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_u_b_h_w(m1_u_b_h_w),
        .m0_gnt(f_m0_gnt), .m1_gnt(f_m1_gnt), .m0_rvalid(f_m0_rvalid), .m1_rvalid(f_m1_rvalid),
        .rdata(f_rdata), .err(f_err), .ram_addr(f_ram_addr), .ram_din(f_ram_din), .ram_we(f_ram_we),
        .ram_u_b_h_w(f_ram_u_b_h_w), .ram_dout(f_ram_dout)
    );

    // byte RAM: little-endian, commits on the falling edge, sized/extended reads
    logic [7:0] mem [256] = '{default: 8'h00};
    logic [7:0] ra, b0, b1, b2, b3;

    always @(negedge clk) begin
        if (ram_we) begin
            mem[ram_addr[7:0]] <= ram_din[7:0];
            if (ram_u_b_h_w[1] | ram_u_b_h_w[0]) mem[ram_addr[7:0] + 8'd1] <= ram_din[15:8];
            if (ram_u_b_h_w[1]) begin
                mem[ram_addr[7:0] + 8'd2] <= ram_din[23:16];
                mem[ram_addr[7:0] + 8'd3] <= ram_din[31:24];
            end
        end
    end

    always_comb begin
        ra = ram_addr[7:0];
        b0 = mem[ra];
        b1 = mem[ra + 8'd1];
        b2 = mem[ra + 8'd2];
        b3 = mem[ra + 8'd3];
        if (ram_u_b_h_w[1])      ram_dout = {b3, b2, b1, b0};
        else if (ram_u_b_h_w[0]) ram_dout = ram_u_b_h_w[2] ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
        else                     ram_dout = ram_u_b_h_w[2] ? {24'h0, b0} : {{24{b0[7]}}, b0};
    end

    int vectors = 0;
    int miscompares = 0;
    int ref_last = 1;
    int ref_mem [256] = '{default: 0};

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [31:0] exp_rd;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vq[$];
    logic [2:0] sizes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    function automatic vec_t mk(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] size, input logic [31:0] exp_rd, input logic exp_err, input string name);
        vec_t v;
        v.m = m; v.we = we; v.addr = addr; v.wdata = wdata; v.size = size;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.name = name;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] size);
        return size[1] ? 4 : (size[0] ? 2 : 1);
    endfunction

    // an access is misaligned when its address is not a multiple of its width
    function automatic logic ref_mis(input logic [31:0] addr, input logic [2:0] size);
        return (addr % nbytes(size)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] size);
        int    n = nbytes(size);
        longint v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[(addr + i) % 256]) << (8 * i);
        if (!size[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    task automatic ref_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] size,
                          output logic exp_we, output logic [31:0] exp_rd, output logic exp_err);
        exp_err = ref_mis(addr, size);
        exp_we  = we && !exp_err;
        exp_rd  = 32'h0;
        if (!exp_err) begin
            if (we) begin
                for (int i = 0; i < nbytes(size); i++)
                    ref_mem[(addr + i) % 256] = int'((wdata >> (8 * i)) & 32'hFF);
            end
            exp_rd = ref_load(addr, size);
        end
    endtask

    task automatic drive(input int m, input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] size);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_u_b_h_w = size;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_u_b_h_w = size;
        end
    endtask

    function automatic logic gnt_of(input int m);
        return (m == 0) ? m0_gnt : m1_gnt;
    endfunction

    function automatic logic rv_of(input int m);
        return (m == 0) ? m0_rvalid : m1_rvalid;
    endfunction

    // call shortly after a rising edge with master m's request already driven
    task automatic serve(input int m, input logic exp_we, input logic [31:0] exp_addr,
                         input logic [31:0] exp_rd, input logic exp_err, input string name);
        int cyc = 0;
        #1;
        while (gnt_of(m) !== 1'b1 && cyc < 12) begin
            @(posedge clk); #2;
            cyc++;
        end
        chk({name, ".gnt"}, gnt_of(m), 1'b1);
        chk({name, ".gnt_other"}, gnt_of(1 - m), 1'b0);
        chk({name, ".rv_in_gnt"}, {m1_rvalid, m0_rvalid}, 2'b00);
        ref_last = m;
        @(posedge clk); #1;
        if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
        chk({name, ".acc_we"}, ram_we, exp_we);
        chk({name, ".acc_addr"}, ram_addr, exp_addr);
        chk({name, ".acc_gnt"}, {m1_gnt, m0_gnt}, 2'b00);
        chk({name, ".acc_rv"}, {m1_rvalid, m0_rvalid}, 2'b00);
        @(posedge clk); #1;
        chk({name, ".rvalid"}, rv_of(m), 1'b1);
        chk({name, ".rvalid_other"}, rv_of(1 - m), 1'b0);
        chk({name, ".rdata"}, rdata, exp_rd);
        chk({name, ".err"}, err, exp_err);
        chk({name, ".resp_we"}, ram_we, 1'b0);
        chk({name, ".resp_gnt"}, {m1_gnt, m0_gnt}, 2'b00);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        ew [2];
        logic [31:0] er [2];
        logic        ee [2];
        logic        rwe [2];
        logic [31:0] raddr [2];
        logic [31:0] rwd [2];
        logic [2:0]  rsz [2];
        logic [1:0]  exp2;
        int          w;

        vq.push_back(mk(0, 1'b1, 32'h10,       32'hDEADBEEF, 3'b010, 32'hDEADBEEF, 1'b0, "w_word_10"));
        vq.push_back(mk(0, 1'b0, 32'h10,       32'h0,        3'b010, 32'hDEADBEEF, 1'b0, "r_word_10"));
        vq.push_back(mk(1, 1'b1, 32'h20,       32'h11223344, 3'b010, 32'h11223344, 1'b0, "w_word_20"));
        vq.push_back(mk(1, 1'b1, 32'h21,       32'h0000AAAA, 3'b001, 32'h0,        1'b1, "w_half_21_mis"));
        vq.push_back(mk(1, 1'b0, 32'h20,       32'h0,        3'b010, 32'h11223344, 1'b0, "r_word_20"));
        vq.push_back(mk(0, 1'b1, 32'h13,       32'h00000080, 3'b000, 32'hFFFFFF80, 1'b0, "w_byte_13"));
        vq.push_back(mk(0, 1'b0, 32'h13,       32'h0,        3'b000, 32'hFFFFFF80, 1'b0, "r_byte_s"));
        vq.push_back(mk(0, 1'b0, 32'h13,       32'h0,        3'b100, 32'h00000080, 1'b0, "r_byte_u"));
        vq.push_back(mk(0, 1'b0, 32'h10,       32'h0,        3'b010, 32'h80ADBEEF, 1'b0, "r_word_10b"));
        vq.push_back(mk(0, 1'b0, 32'h12,       32'h0,        3'b001, 32'hFFFF80AD, 1'b0, "r_half_s"));
        vq.push_back(mk(1, 1'b0, 32'h10,       32'h0,        3'b101, 32'h0000BEEF, 1'b0, "r_half_u"));
        vq.push_back(mk(0, 1'b0, 32'h12,       32'h0,        3'b010, 32'h0,        1'b1, "r_word_mis"));
        vq.push_back(mk(1, 1'b1, 32'h10000000, 32'h0000005A, 3'b000, 32'h0000005A, 1'b0, "w_uart"));
        vq.push_back(mk(0, 1'b0, 32'h11,       32'h0,        3'b010, 32'h0,        1'b1, "r_word_11_mis"));
        vq.push_back(mk(0, 1'b1, 32'h31,       32'h12345678, 3'b010, 32'h0,        1'b1, "w_word_31_mis"));

        // reset with both masters requesting reads of address 0
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
        drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
        repeat (3) @(posedge clk);
        #1;
        chk("rst.gnt", {m1_gnt, m0_gnt}, 2'b00);
        chk("rst.rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        chk("rst.ram_we", ram_we, 1'b0);
        chk("rst.err", err, 1'b0);
        chk("rst.rdata", rdata, 32'h0);
        chk("rst.ram_addr", ram_addr, 32'h0);
        chk("rst.ram_din", ram_din, 32'h0);
        chk("rst.fp_gnt", {f_m1_gnt, f_m0_gnt}, 2'b00);

        // both held high from reset: round robin vs fixed priority
        rst_n = 1'b1;
        ref_last = 1;
        for (int i = 0; i < 12; i++) begin
            #1;
            exp2 = (i % 3 != 0) ? 2'b00 : (((i / 3) % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("rr.c%0d", i), {m1_gnt, m0_gnt}, exp2);
            chk($sformatf("fp.c%0d", i), {f_m1_gnt, f_m0_gnt}, (i % 3 == 0) ? 2'b01 : 2'b00);
            chk($sformatf("rr.gnt_rv.c%0d", i), {m1_gnt | m0_gnt, m1_rvalid | m0_rvalid}, (i % 3 == 0) ? 2'b10 : ((i % 3 == 2) ? 2'b01 : 2'b00));
            if (i == 11) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            @(posedge clk); #1;
        end
        ref_last = 1;

        foreach (vq[i]) begin
            ref_op(vq[i].we, vq[i].addr, vq[i].wdata, vq[i].size, ew[0], er[0], ee[0]);
            drive(vq[i].m, 1'b1, vq[i].we, vq[i].addr, vq[i].wdata, vq[i].size);
            serve(vq[i].m, vq[i].we & ~vq[i].exp_err, vq[i].addr, vq[i].exp_rd, vq[i].exp_err, vq[i].name);
        end

        // reset during the RAM cycle of an m0 read aborts it
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
        #1;
        chk("abort.m0_gnt", m0_gnt, 1'b1);
        @(posedge clk); #1;
        m0_req = 1'b0;
        drive(1, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("abort.rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        chk("abort.m1_gnt_now", m1_gnt, 1'b1);
        chk("abort.rdata", rdata, 32'h0);
        ref_last = 1;
        ref_op(1'b0, 32'h20, 32'h0, 3'b010, ew[1], er[1], ee[1]);
        serve(1, ew[1], 32'h20, er[1], ee[1], "abort.m1");

        // random traffic, single and simultaneous requests
        for (int k = 0; k < 40; k++) begin
            for (int j = 0; j < 2; j++) begin
                rsz[j]   = sizes[$urandom_range(0, 4)];
                raddr[j] = $urandom();
                if ($urandom_range(0, 3) != 0) raddr[j] = raddr[j] & ~(32'(nbytes(rsz[j])) - 32'd1);
                rwd[j]   = $urandom();
                rwe[j]   = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 2) == 0) begin
                w = 1 - ref_last;
                drive(0, 1'b1, rwe[0], raddr[0], rwd[0], rsz[0]);
                drive(1, 1'b1, rwe[1], raddr[1], rwd[1], rsz[1]);
                ref_op(rwe[w], raddr[w], rwd[w], rsz[w], ew[w], er[w], ee[w]);
                ref_op(rwe[1 - w], raddr[1 - w], rwd[1 - w], rsz[1 - w], ew[1 - w], er[1 - w], ee[1 - w]);
                serve(w, ew[w], raddr[w], er[w], ee[w], $sformatf("rnd%0d.win", k));
                serve(1 - w, ew[1 - w], raddr[1 - w], er[1 - w], ee[1 - w], $sformatf("rnd%0d.lose", k));
            end else begin
                w = $urandom_range(0, 1);
                drive(w, 1'b1, rwe[w], raddr[w], rwd[w], rsz[w]);
                ref_op(rwe[w], raddr[w], rwd[w], rsz[w], ew[w], er[w], ee[w]);
                serve(w, ew[w], raddr[w], er[w], ee[w], $sformatf("rnd%0d.single", k));
            end
        end

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FAIR, default 1, meaning: 1 = round-robin between masters, 0 = fixed priority to master 0.
REQ-002 Port clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous, active-low.
REQ-004 Ports m0_req / m1_req  input  1  access request from master 0 (CPU data port) / master 1 (debug loader).
REQ-005 Ports m0_we / m1_we  input  1  request is a write.
REQ-006 Ports m0_addr / m1_addr  input  32  byte address.
REQ-007 Ports m0_wdata / m1_wdata  input  32  write data, right-aligned.
REQ-008 Ports m0_u_b_h_w / m1_u_b_h_w  input  3  size code: bit0 half, bit1 word, neither = byte; bit2 unsigned load.
REQ-009 Ports m0_gnt / m1_gnt  output  1  one-cycle pulse: request accepted.
REQ-010 Ports m0_rvalid / m1_rvalid  output  1  one-cycle pulse: access complete, rdata/err valid.
REQ-011 Ports rdata  output  32  load result, shared by both masters, qualified by mX_rvalid.
REQ-012 Port err  output  1  misaligned-access flag, qualified by mX_rvalid.
REQ-013 Ports ram_addr  output  32, ram_din  output  32, ram_we  output  1, ram_u_b_h_w  output  3  byte-RAM drive signals.
REQ-014 Port ram_dout  input  32  combinational read data from byte RAM.

Function
REQ-015 FSM states IDLE, ACCESS, RESP; one access in flight at a time.
REQ-016 IDLE: no req -> stay IDLE; any req -> select winner, pulse winner gnt, latch its we/addr/wdata/u_b_h_w and owner id, -> ACCESS.
REQ-017 Arbitration, FAIR=1: single requester wins; both request -> master not granted most recently wins; last-winner pointer resets to master 1 (master 0 wins first tie).
REQ-018 Arbitration, FAIR=0: master 0 always wins ties.
REQ-019 ACCESS: ram_addr/ram_din/ram_u_b_h_w driven from latched registers; ram_we = latched we AND NOT misaligned for exactly this cycle (RAM commits on falling edge within it); ram_dout captured into rdata at cycle end; -> RESP.
REQ-020 Misaligned: half with addr[0]=1, or word with addr[1:0]!=0; no RAM write; err=1; rdata=0.
REQ-021 RESP: owner's rvalid=1 for one cycle with rdata/err stable; non-owner rvalid=0; -> IDLE.
REQ-022 Latency: gnt in cycle N, ram_we (if write) in N+1, rvalid in N+2; max throughput one access per 3 cycles.
REQ-023 Writes also produce rvalid (completion ack); rdata for writes = ram_dout sampled in ACCESS, err per REQ-020.
REQ-024 Requests seen in ACCESS or RESP are ignored; masters hold req and fields until gnt; the req input value in the gnt cycle is not re-evaluated until IDLE.
REQ-025 ram_we is 0 in IDLE and RESP under all conditions; ram_addr/ram_din hold last latched values outside ACCESS.
REQ-026 Address 32'h10000000 (sim UART) passes through unmodified; the arbiter applies no address decoding.
REQ-027 gnt and rvalid never asserted to both masters in the same cycle; gnt and rvalid never asserted in the same cycle.

Reset
REQ-028 rst_n=0 at a rising edge -> state IDLE, all gnt/rvalid/ram_we/err = 0, rdata = 0, latched registers = 0, last-winner = master 1.
REQ-029 Reset in ACCESS or RESP aborts the access: no rvalid issued; a write whose ACCESS cycle contains the reset edge may or may not have committed; masters must re-request.

Verification
REQ-030 m0 write word 0xDEADBEEF @0x10, then m0 read word @0x10 -> gnt at N, ram_we high at N+1 only, rvalid at N+2; read rdata=0xDEADBEEF, err=0.
REQ-031 FAIR=1, m0_req and m1_req held high continuously from reset -> grant order m0, m1, m0, m1, gnt spacing 3 cycles.
REQ-032 FAIR=0, both held high -> m0 granted every time, m1 never.
REQ-033 m1 half write @0x21 -> ram_we stays 0, m1_rvalid with err=1, rdata=0; memory @0x20..0x23 unchanged on later read.
REQ-034 m0 byte read @0x13 holding 0x80, signed -> rdata=0xFFFFFF80; unsigned (bit2=1) -> 0x00000080.
REQ-035 rst_n=0 during ACCESS of m0 read -> no m0_rvalid, state IDLE next cycle, subsequent m1 request granted immediately.
